// File: rtl/nclic_arbiter_pkg.sv
// Shared types for the NCLIC interrupt arbiter: table entry layout and FSM states.
package nclic_arbiter_pkg;

    localparam int unsigned PrioBits = 3;

    typedef struct packed {
        logic [PrioBits-1:0] prio;
        logic                enable;
        logic                pending;
    } int_entry_t;

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        REQ   = 2'd1,
        CLEAR = 2'd2
    } arb_state_t;

endpackage

// File: rtl/nclic_prio_cmp.sv
// Candidate test for one table entry and whether it beats the current best.
module nclic_prio_cmp
    import nclic_arbiter_pkg::*;
(
    input  int_entry_t          entry,
    input  logic [PrioBits-1:0] threshold,
    input  logic                best_valid,
    input  logic [PrioBits-1:0] best_prio,
    output logic                is_cand_c,
    output logic                beats_c
);

    // Strict compares: equal priority never displaces an earlier (lower) index.
    always_comb begin
        is_cand_c = entry.pending & entry.enable & (entry.prio > threshold);
        beats_c   = is_cand_c & (~best_valid | (entry.prio > best_prio));
    end

endmodule

// File: rtl/nclic_arbiter.sv
// Sweeping interrupt arbiter: one entry per cycle, req/ack to the core, pending write-back on ack.
module nclic_arbiter
    import nclic_arbiter_pkg::*;
#(
    parameter int unsigned TableSize = 8,
    localparam int unsigned TableSizeBits = $clog2(TableSize)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  int_entry_t               entries [TableSize],
    input  logic [PrioBits-1:0]      threshold,
    input  logic                     irq_ack,
    output logic                     irq_req,
    output logic [TableSizeBits-1:0] irq_id,
    output logic [PrioBits-1:0]      irq_prio,
    output int_entry_t               ext_data,
    output logic                     ext_write_enable,
    output logic [TableSizeBits-1:0] ext_idx
);

    localparam logic [TableSizeBits-1:0] LastIdx = TableSizeBits'(TableSize - 1);

    arb_state_t                state_q, state_d;
    logic [TableSizeBits-1:0]  idx_q, idx_d;
    logic                      best_valid_q, best_valid_d;
    logic [TableSizeBits-1:0]  best_id_q, best_id_d;
    logic [PrioBits-1:0]       best_prio_q, best_prio_d;

    logic                      irq_req_d;
    logic [TableSizeBits-1:0]  irq_id_d;
    logic [PrioBits-1:0]       irq_prio_d;
    int_entry_t                ext_data_d;
    logic                      ext_write_enable_d;
    logic [TableSizeBits-1:0]  ext_idx_d;

    int_entry_t                cmp_entry;
    logic                      is_cand;
    logic                      beats;

    // One comparator serves both the sweep slot and the held request's withdraw check.
    assign cmp_entry = (state_q == REQ) ? entries[irq_id] : entries[idx_q];

    nclic_prio_cmp u_cmp (
        .entry      (cmp_entry),
        .threshold  (threshold),
        .best_valid (best_valid_q),
        .best_prio  (best_prio_q),
        .is_cand_c  (is_cand),
        .beats_c    (beats)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= SCAN;
            idx_q            <= '0;
            best_valid_q     <= 1'b0;
            best_id_q        <= '0;
            best_prio_q      <= '0;
            irq_req          <= 1'b0;
            irq_id           <= '0;
            irq_prio         <= '0;
            ext_data         <= '0;
            ext_write_enable <= 1'b0;
            ext_idx          <= '0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            best_valid_q     <= best_valid_d;
            best_id_q        <= best_id_d;
            best_prio_q      <= best_prio_d;
            irq_req          <= irq_req_d;
            irq_id           <= irq_id_d;
            irq_prio         <= irq_prio_d;
            ext_data         <= ext_data_d;
            ext_write_enable <= ext_write_enable_d;
            ext_idx          <= ext_idx_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        idx_d              = idx_q;
        best_valid_d       = best_valid_q;
        best_id_d          = best_id_q;
        best_prio_d        = best_prio_q;
        irq_req_d          = irq_req;
        irq_id_d           = irq_id;
        irq_prio_d         = irq_prio;
        ext_data_d         = '0;
        ext_write_enable_d = 1'b0;
        ext_idx_d          = '0;

        unique case (state_q)
            SCAN: begin
                if (beats) begin
                    best_valid_d = 1'b1;
                    best_id_d    = idx_q;
                    best_prio_d  = cmp_entry.prio;
                end
                if (idx_q == LastIdx) begin
                    // End of sweep: present the winner or start over with a clean best.
                    idx_d        = '0;
                    best_valid_d = 1'b0;
                    best_id_d    = '0;
                    best_prio_d  = '0;
                    if (beats || best_valid_q) begin
                        state_d    = REQ;
                        irq_req_d  = 1'b1;
                        irq_id_d   = beats ? idx_q : best_id_q;
                        irq_prio_d = beats ? cmp_entry.prio : best_prio_q;
                    end
                end else begin
                    idx_d = idx_q + TableSizeBits'(1);
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d            = CLEAR;
                    irq_req_d          = 1'b0;
                    ext_write_enable_d = 1'b1;
                    ext_idx_d          = irq_id;
                    ext_data_d         = entries[irq_id];
                    ext_data_d.pending = 1'b0;
                end else if (!is_cand) begin
                    state_d   = SCAN;
                    idx_d     = '0;
                    irq_req_d = 1'b0;
                end
            end
            CLEAR: begin
                state_d      = SCAN;
                idx_d        = '0;
                best_valid_d = 1'b0;
                best_id_d    = '0;
                best_prio_d  = '0;
            end
            default: begin
                state_d      = SCAN;
                idx_d        = '0;
                best_valid_d = 1'b0;
                irq_req_d    = 1'b0;
            end
        endcase
    end

endmodule
